// File: rtl/gpr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gpr_pkg                                                    |
// | Description : Shared defaults and constants for the GPR file and its     |
// |               scoreboard.                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package gpr_pkg;

   localparam int c_xlen_def    = 64;   // register data width
   localparam int c_nregs_def   = 32;   // register count (power of two)
   localparam int c_nrports_def = 2;    // independent read ports

   // Hard-wired zero register; never written, never busy.
   localparam int X0_ID = 0;

endpackage : gpr_pkg
`default_nettype wire

// File: rtl/gpr_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gpr_scoreboard                                             |
// | Description : Per-register busy bits plus a running count of busy        |
// |               registers. A set and a clear of the same register on one   |
// |               edge leave it busy. x0 is never marked busy.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter  int NREGS = c_nregs_def,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_set_valid,
   input  logic [AW-1:0]    i_set_id,
   input  logic             i_clr_valid,
   input  logic [AW-1:0]    i_clr_id,
   output logic [NREGS-1:0] o_busy,
   output logic [AW:0]      o_cnt
);

   logic             w_set;
   logic             w_clr;
   logic             w_inc;
   logic             w_dec;
   logic [NREGS-1:0] w_busy_nxt;
   logic [AW:0]      w_cnt_nxt;
   logic [NREGS-1:0] r_busy;
   logic [AW:0]      r_cnt;

   // Next busy vector and count delta; set is applied after clear so it wins.
   always_comb begin
      w_set = i_set_valid && (i_set_id != AW'(X0_ID));
      w_clr = i_clr_valid && (i_clr_id != AW'(X0_ID));

      w_busy_nxt = r_busy;
      if (w_clr) w_busy_nxt[i_clr_id] = 1'b0;
      if (w_set) w_busy_nxt[i_set_id] = 1'b1;
      w_busy_nxt[X0_ID] = 1'b0;

      // A clear that is overridden by a same-register set does not decrement.
      w_inc = w_set && !r_busy[i_set_id];
      w_dec = w_clr && r_busy[i_clr_id] && !(w_set && (i_set_id == i_clr_id));
      w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
   end

   // Busy state and count registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign o_busy = r_busy;
   assign o_cnt  = r_cnt;

endmodule : gpr_scoreboard
`default_nettype wire

// File: rtl/gpr_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gpr_file_sb                                                |
// | Description : General-purpose register file with combinational read     |
// |               ports and a busy scoreboard for WAW/RAW hazard tracking.   |
// |               Define GPR_FILE_BYPASS_EN to forward the current writeback |
// |               to readers and to the issue-ready check.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gpr_file_sb
   import gpr_pkg::*;
#(
   parameter  int XLEN    = c_xlen_def,
   parameter  int NREGS   = c_nregs_def,
   parameter  int NRPORTS = c_nrports_def,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_id,
   input  logic [XLEN-1:0]         wr_data,
   input  logic [NRPORTS*AW-1:0]   rd_id,
   output logic [NRPORTS*XLEN-1:0] rd_data,
   output logic [NRPORTS-1:0]      rd_busy,
   input  logic                    iss_valid,
   input  logic [AW-1:0]           iss_rd,
   output logic                    iss_ready,
   output logic [AW:0]             busy_cnt
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] w_busy;
   logic             w_wr;
   logic             w_claim_clr;
   logic             w_fire;

   // Writes to x0 are dropped so it always reads back zero.
   assign w_wr = wr_en && (wr_id != AW'(X0_ID));

   // Register array: reset clears every entry, otherwise accept writeback.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (w_wr) begin
         r_regs[wr_id] <= wr_data;
      end
   end

   // One read mux per port, with optional same-cycle forwarding.
   for (genvar p = 0; p < NRPORTS; p++) begin : g_rd_port
      logic [AW-1:0] w_id;
      logic          w_fwd;

      assign w_id = rd_id[p*AW +: AW];
`ifdef GPR_FILE_BYPASS_EN
      assign w_fwd = w_wr && (wr_id == w_id);
`else
      assign w_fwd = 1'b0;
`endif
      assign rd_data[p*XLEN +: XLEN] = w_fwd ? wr_data : r_regs[w_id];
      assign rd_busy[p]              = w_busy[w_id] && !w_fwd;
   end

   // Issue acceptance: x0 claims always pass; otherwise the target must be
   // idle, or (with forwarding) be released by this cycle's writeback.
   always_comb begin
`ifdef GPR_FILE_BYPASS_EN
      w_claim_clr = w_wr && (wr_id == iss_rd);
`else
      w_claim_clr = 1'b0;
`endif
      iss_ready = (iss_rd == AW'(X0_ID)) || !w_busy[iss_rd] || w_claim_clr;
      w_fire    = iss_valid && iss_ready;
   end

   gpr_scoreboard #(
      .NREGS      (NREGS)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_set_valid(w_fire),
      .i_set_id   (iss_rd),
      .i_clr_valid(wr_en),
      .i_clr_id   (wr_id),
      .o_busy     (w_busy),
      .o_cnt      (busy_cnt)
   );

endmodule : gpr_file_sb
`default_nettype wire

// File: tb/tb_gpr_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gpr_file_sb                                             |
// | Description : Self-checking bench for gpr_file_sb: directed scenarios    |
// |               followed by random traffic against an array/flag model.    |
// |               Honours GPR_FILE_BYPASS_EN when defined.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gpr_file_sb;

   localparam int XLEN    = 64;
   localparam int NREGS   = 32;
   localparam int NRPORTS = 2;
   localparam int AW      = 5;
`ifdef GPR_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    wr_en;
   logic [AW-1:0]           wr_id;
   logic [XLEN-1:0]         wr_data;
   logic [NRPORTS*AW-1:0]   rd_id;
   logic [NRPORTS*XLEN-1:0] rd_data;
   logic [NRPORTS-1:0]      rd_busy;
   logic                    iss_valid;
   logic [AW-1:0]           iss_rd;
   logic                    iss_ready;
   logic [AW:0]             busy_cnt;

   // Reference model: register contents and a busy flag per register.
   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gpr_file_sb #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NRPORTS  (NRPORTS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_id    (wr_id),
      .wr_data  (wr_data),
      .rd_id    (rd_id),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .iss_valid(iss_valid),
      .iss_rd   (iss_rd),
      .iss_ready(iss_ready),
      .busy_cnt (busy_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NREGS; i++) if (m_busy[i]) c++;
      return c;
   endfunction

   function automatic bit m_hit(input logic [AW-1:0] id);
      return BYP && wr_en && (wr_id != 0) && (wr_id == id);
   endfunction

   function automatic logic [AW-1:0] pick_id();
      return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                         : AW'($urandom_range(0, NREGS-1));
   endfunction

   // Compare every output against the model, then advance one clock edge.
   task automatic cycle();
      logic [AW-1:0] id;
      bit            rdy;
      bit            fire;
      @(negedge clk);
      for (int p = 0; p < NRPORTS; p++) begin
         id = rd_id[p*AW +: AW];
         chk($sformatf("rd_data%0d", p), 64'(rd_data[p*XLEN +: XLEN]),
             m_hit(id) ? 64'(wr_data) : 64'(m_regs[id]));
         chk($sformatf("rd_busy%0d", p), 64'(rd_busy[p]),
             64'(m_busy[id] && !m_hit(id)));
      end
      rdy = (iss_rd == 0) || !m_busy[iss_rd] || m_hit(iss_rd);
      chk("iss_ready", 64'(iss_ready), 64'(rdy));
      chk("busy_cnt", 64'(busy_cnt), 64'(m_count()));
      fire = iss_valid && rdy;
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (wr_en && wr_id != 0) begin
            m_regs[wr_id] = wr_data;
            m_busy[wr_id] = 1'b0;
         end
         if (fire && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
      #1;
   endtask

   // Directed scenarios, then random traffic, then the summary.
   initial begin
      logic [XLEN-1:0] v;
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      rst_n = 1'b0; wr_en = 1'b0; wr_id = '0; wr_data = '0;
      rd_id = '0; iss_valid = 1'b0; iss_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Post-reset read of x5 on both ports.
      rd_id = {5'd5, 5'd5}; iss_rd = 5'd5;
      #1;
      chk("rst_rd_data", rd_data[63:0], 64'd0);
      chk("rst_rd_busy", 64'(rd_busy), 64'd0);
      chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
      chk("rst_iss_ready", 64'(iss_ready), 64'd1);
      cycle();

      // Claim x7, then observe it busy.
      iss_valid = 1'b1; iss_rd = 5'd7;
      cycle();
      iss_valid = 1'b0; rd_id = {5'd5, 5'd7};
      #1;
      chk("x7_rd_busy", 64'(rd_busy[0]), 64'd1);
      chk("x7_busy_cnt", 64'(busy_cnt), 64'd1);
      chk("x7_iss_ready", 64'(iss_ready), 64'd0);
      cycle();

      // Writeback to x7 while reading it.
      v = 64'hDEAD_BEEF_0000_0001;
      wr_en = 1'b1; wr_id = 5'd7; wr_data = v; iss_rd = 5'd0;
      #1;
      chk("wb7_rd_data", rd_data[63:0], BYP ? v : 64'd0);
      chk("wb7_rd_busy", 64'(rd_busy[0]), BYP ? 64'd0 : 64'd1);
      cycle();
      wr_en = 1'b0;
      #1;
      chk("wb7_stored", rd_data[63:0], v);
      chk("wb7_busy_cnt", 64'(busy_cnt), 64'd0);
      cycle();

      // Write and claim x3 on the same edge: set wins.
      wr_en = 1'b1; wr_id = 5'd3; wr_data = {$urandom, $urandom};
      iss_valid = 1'b1; iss_rd = 5'd3;
      cycle();
      wr_en = 1'b0; iss_valid = 1'b0; rd_id = {5'd5, 5'd3};
      #1;
      chk("x3_rd_busy", 64'(rd_busy[0]), 64'd1);
      chk("x3_busy_cnt", 64'(busy_cnt), 64'd1);
      cycle();

      // x0 ignores writes and claims.
      wr_en = 1'b1; wr_id = 5'd0; wr_data = '1;
      iss_valid = 1'b1; iss_rd = 5'd0; rd_id = '0;
      #1;
      chk("x0_iss_ready", 64'(iss_ready), 64'd1);
      chk("x0_rd_data", rd_data[63:0], 64'd0);
      cycle();
      wr_en = 1'b0; iss_valid = 1'b0;
      #1;
      chk("x0_rd_data_after", rd_data[127:64], 64'd0);
      chk("x0_rd_busy", 64'(rd_busy), 64'd0);
      chk("x0_busy_cnt", 64'(busy_cnt), 64'd1);
      cycle();

      // Fill x1..x31 busy, then reset with a write and a claim pending.
      iss_valid = 1'b1;
      for (int r = 1; r < NREGS; r++) begin
         iss_rd = AW'(r);
         cycle();
      end
      iss_valid = 1'b0;
      #1;
      chk("full_busy_cnt", 64'(busy_cnt), 64'(NREGS-1));
      rst_n = 1'b0; wr_en = 1'b1; wr_id = 5'd9; wr_data = {$urandom, $urandom};
      iss_valid = 1'b1; iss_rd = 5'd9;
      cycle();
      rst_n = 1'b1; wr_en = 1'b0; iss_valid = 1'b0;
      #1;
      chk("mid_rst_busy_cnt", 64'(busy_cnt), 64'd0);
      chk("mid_rst_iss_ready", 64'(iss_ready), 64'd1);
      for (int r = 0; r < NREGS; r++) begin
         rd_id = {AW'(r), AW'(r)};
         #1;
         chk($sformatf("mid_rst_x%0d", r), rd_data[63:0] | rd_data[127:64], 64'd0);
         chk($sformatf("mid_rst_busy_x%0d", r), 64'(rd_busy), 64'd0);
         cycle();
      end

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(0, 299) != 0);
         wr_en     = ($urandom_range(0, 2) == 0);
         wr_id     = pick_id();
         wr_data   = {$urandom, $urandom};
         iss_valid = ($urandom_range(0, 1) == 0);
         iss_rd    = pick_id();
         rd_id     = {pick_id(), pick_id()};
         if ($urandom_range(0, 3) == 0) rd_id[AW-1:0] = wr_id;
         if ($urandom_range(0, 3) == 0) iss_rd = wr_id;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_gpr_file_sb
`default_nettype wire
